// File: rtl/systolic_seq_counter_if.sv
// Handshake/status bundle between the tile controller and the systolic sequencer.
// The controller takes the master side and the sequencer the slave side.
interface systolic_seq_counter_if #(
    parameter int DIM   = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] k_len;
    logic             stall;
    logic             busy;
    logic [2:0]       phase;
    logic [CNT_W-1:0] count;
    logic             acc_clr;
    logic [DIM-1:0]   feed_en;
    logic             done;
    logic             err;

    modport master (
        output start, k_len, stall,
        input  busy, phase, count, acc_clr, feed_en, done, err
    );

    modport slave (
        input  start, k_len, stall,
        output busy, phase, count, acc_clr, feed_en, done, err
    );
endinterface

// File: rtl/systolic_seq_counter.sv
// Start/done sequencer for a DIM x DIM output-stationary systolic array: steps through
// CLR -> FEED -> DRAIN -> DONE and produces the diagonally skewed per-lane feed enables.
module systolic_seq_counter #(
    parameter int DIM   = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_seq_counter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int            EXT_W      = CNT_W + 2;
    localparam logic [CNT_W:0] K_MAX      = (CNT_W+1)'((1 << CNT_W) - DIM);
    localparam logic [CNT_W:0] FEED_OFS   = (CNT_W+1)'(DIM - 2);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(DIM - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             err_q, err_d;

    logic             k_legal;
    logic [CNT_W:0]   feed_end;
    logic             feed_last;
    logic             drain_last;
    logic [DIM-1:0]   feed_en;

    // Upper bound keeps the longest FEED count (K+DIM-2) below wrap-around.
    assign k_legal    = (bus.k_len != '0) && ({1'b0, bus.k_len} <= K_MAX);
    assign feed_end   = {1'b0, k_q} + FEED_OFS;
    assign feed_last  = ({1'b0, count_q} == feed_end);
    assign drain_last = (count_q == DRAIN_END);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        k_d     = k_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // Stall is deliberately ignored here so done/err always pulse exactly once.
                count_d = '0;
                if (state_q == S_DONE) state_d = S_IDLE;
                if (bus.start) begin
                    if (k_legal) begin
                        state_d = S_CLR;
                        k_d     = bus.k_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLR: begin
                if (!bus.stall) begin
                    state_d = S_FEED;
                    count_d = '0;
                end
            end
            S_FEED: begin
                if (!bus.stall) begin
                    if (feed_last) begin
                        state_d = S_DRAIN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.stall) begin
                    if (drain_last) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    // Lane i is live for counts i .. i+K-1, giving the one-cycle diagonal skew per lane.
    always_comb begin
        feed_en = '0;
        if ((state_q == S_FEED) && !bus.stall) begin
            for (int i = 0; i < DIM; i++) begin
                if ((EXT_W'(count_q) >= EXT_W'(i)) &&
                    (EXT_W'(count_q) < (EXT_W'(i) + EXT_W'(k_q)))) begin
                    feed_en[i] = 1'b1;
                end
            end
        end
    end

    assign bus.busy    = (state_q == S_CLR) || (state_q == S_FEED) || (state_q == S_DRAIN);
    assign bus.phase   = state_q;
    assign bus.count   = count_q;
    assign bus.acc_clr = (state_q == S_CLR) && !bus.stall;
    assign bus.feed_en = feed_en;
    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_systolic_seq_counter.sv
// Bench for systolic_seq_counter: a hand-written vector table, directed multi-cycle
// sequences and randomized traffic compared against a run-progress reference model.
module tb_systolic_seq_counter;
    localparam int DIM   = 4;
    localparam int CNT_W = 8;

    typedef logic [18:0] ovec_t;  // {busy, phase[3], count[8], acc_clr, feed_en[4], done, err}

    typedef struct {
        bit          r;
        bit          s;
        logic [7:0]  k;
        bit          st;
        ovec_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_seq_counter_if #(.DIM(DIM), .CNT_W(CNT_W)) bus ();

    systolic_seq_counter #(.DIM(DIM), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference: a run is a count of unstalled cycles e since entering CLR.
    // e=0 is CLR, e=1..K+DIM-1 is FEED, the next DIM values are DRAIN, then DONE.
    int m_mode = 0;  // 0 idle, 1 running, 2 done
    int m_e    = 0;
    int m_k    = 0;
    bit m_err  = 1'b0;

    function automatic bit legal(int k);
        return (k >= 1) && (k <= (1 << CNT_W) - DIM);
    endfunction

    function automatic ovec_t mk(bit busy, int ph, int cnt, bit acc, logic [3:0] fe, bit dn, bit er);
        return {busy, 3'(ph), 8'(cnt), acc, fe, dn, er};
    endfunction

    function automatic ovec_t model_out(bit st);
        int         flen = m_k + DIM - 1;
        int         ph = 0;
        int         c = 0;
        logic [3:0] fe = '0;
        bit         acc = 0, bz = 0, dn = 0;
        if (m_mode == 1) begin
            bz = 1;
            if (m_e == 0) begin
                ph = 1; acc = !st;
            end else if (m_e <= flen) begin
                ph = 2; c = m_e - 1;
                for (int i = 0; i < DIM; i++)
                    if (!st && c >= i && c < i + m_k) fe[i] = 1'b1;
            end else begin
                ph = 3; c = m_e - 1 - flen;
            end
        end else if (m_mode == 2) begin
            ph = 4; dn = 1;
        end
        return mk(bz, ph, c, acc, fe, dn, m_err);
    endfunction

    task automatic model_update();
        bit ok, nerr;
        if (rst) begin
            m_mode = 0; m_e = 0; m_k = 0; m_err = 0;
        end else begin
            ok   = legal(int'(bus.k_len));
            nerr = (m_mode != 1) && bus.start && !ok;
            if (m_mode == 1) begin
                if (!bus.stall) begin
                    if (m_e == m_k + 2 * DIM - 1) m_mode = 2;
                    else m_e++;
                end
            end else if (bus.start && ok) begin
                m_mode = 1; m_e = 0; m_k = int'(bus.k_len);
            end else begin
                m_mode = 0;
            end
            m_err = nerr;
        end
    endtask

    function automatic ovec_t dut_out();
        return {bus.busy, bus.phase, bus.count, bus.acc_clr, bus.feed_en, bus.done, bus.err};
    endfunction

    task automatic check(string name, ovec_t got, ovec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%05h expected=%05h", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic drive(bit r, bit s, logic [7:0] k, bit st);
        @(negedge clk);
        rst = r; bus.start = s; bus.k_len = k; bus.stall = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
    endtask

    task automatic step(bit r, bit s, logic [7:0] k, bit st, string name);
        drive(r, s, k, st);
        check(name, dut_out(), model_out(st));
        tick();
    endtask

    // Starts a run with k, optionally holding start, stalling `stalls` cycles at FEED count 3.
    // Returns the cycle offset from the start cycle to the done cycle (-1 if never seen).
    task automatic run(logic [7:0] k, bit hold, int stalls, int bound, output int off, output int maxc);
        int t0;
        int left = stalls;
        bit st;
        bit fin = 0;
        off = -1; maxc = 0;
        drive(0, 1, k, 0);
        check("run_start", dut_out(), model_out(0));
        t0 = cyc;
        tick();
        for (int n = 0; n < bound && !fin; n++) begin
            @(negedge clk);
            st = (left > 0) && (bus.phase == 3'd2) && (bus.count == 8'd3);
            if (st) left--;
            rst = 0; bus.start = hold; bus.k_len = k; bus.stall = st;
            #1;
            check("run", dut_out(), model_out(st));
            if (st) begin
                check_int("stall_count_hold", int'(bus.count), 3);
                check_int("stall_feed_mask", int'(bus.feed_en), 0);
            end
            if (bus.phase == 3'd2 && int'(bus.count) > maxc) maxc = int'(bus.count);
            if (bus.done) begin
                off = cyc - t0;
                fin = 1;
            end
            tick();
        end
    endtask

    vec_t vecs[$];
    int   off, maxc, c0;
    bit   fin;

    initial begin
        rst = 1; bus.start = 0; bus.k_len = '0; bus.stall = 0;
        drive(1, 0, 0, 0);
        tick();

        // Table: reset state, one K=4 run, then two rejected starts.
        vecs.push_back('{1, 0, 8'd0, 0, mk(0, 0, 0, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 1, 8'd4, 0, mk(0, 0, 0, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 1, 0, 1, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 0, 0, 4'b0001, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 1, 0, 4'b0011, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 2, 0, 4'b0111, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 3, 0, 4'b1111, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 4, 0, 4'b1110, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 5, 0, 4'b1100, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 2, 6, 0, 4'b1000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 3, 0, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 3, 1, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 3, 2, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(1, 3, 3, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(0, 4, 0, 0, 4'b0000, 1, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(0, 0, 0, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 1, 8'd0, 0, mk(0, 0, 0, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(0, 0, 0, 0, 4'b0000, 0, 1)});
        vecs.push_back('{0, 1, 8'd253, 0, mk(0, 0, 0, 0, 4'b0000, 0, 0)});
        vecs.push_back('{0, 0, 8'd0, 0, mk(0, 0, 0, 0, 4'b0000, 0, 1)});
        vecs.push_back('{0, 0, 8'd0, 1, mk(0, 0, 0, 0, 4'b0000, 0, 0)});
        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].k, vecs[i].st);
            check($sformatf("tbl%0d", i), dut_out(), vecs[i].exp);
            tick();
        end

        // Largest legal K: FEED reaches 254, done at t+1+255+4+1.
        run(8'd252, 0, 0, 400, off, maxc);
        check_int("kmax_feed_peak", maxc, 254);
        check_int("kmax_done_latency", off, 261);
        step(0, 0, 0, 0, "kmax_idle");

        // Three stall cycles at FEED count 3 push done out by exactly 3.
        run(8'd4, 0, 3, 100, off, maxc);
        check_int("stall_done_latency", off, 16);
        step(0, 0, 0, 0, "stall_idle");

        // Start held through the whole run: ignored while busy, re-accepted in DONE.
        run(8'd2, 1, 0, 100, off, maxc);
        check_int("k2_done_latency", off, 11);
        drive(0, 0, 0, 0);
        check_int("b2b_clr_phase", int'(bus.phase), 1);
        check("b2b_clr", dut_out(), model_out(0));
        c0 = cyc;
        tick();
        fin = 0;
        for (int n = 0; n < 100 && !fin; n++) begin
            drive(0, 0, 0, 0);
            check("b2b_run", dut_out(), model_out(0));
            if (bus.done) begin
                check_int("b2b_done_latency", cyc - c0, 10);
                fin = 1;
            end
            tick();
        end
        check_int("b2b_done_seen", int'(fin), 1);

        // Reset mid-FEED returns everything to zero; a fresh run behaves normally.
        step(0, 1, 8'd5, 0, "mid_start");
        for (int n = 0; n < 4; n++) step(0, 0, 0, 0, "mid_feed");
        drive(1, 0, 0, 0);
        check_int("mid_phase_before_rst", int'(bus.phase), 2);
        tick();
        drive(0, 0, 0, 0);
        check("rst_mid_outputs", dut_out(), mk(0, 0, 0, 0, 4'b0000, 0, 0));
        tick();
        run(8'd3, 0, 0, 100, off, maxc);
        check_int("post_rst_done_latency", off, 12);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            bit         r, s, st;
            logic [7:0] k;
            int         sel;
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 30);
            st  = ($urandom_range(0, 99) < 25);
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      k = 8'd0;
            else if (sel == 1) k = 8'($urandom_range(253, 255));
            else if (sel == 2) k = 8'd252;
            else               k = 8'($urandom_range(1, 8));
            step(r, s, k, st, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
